serial_subtractor: RTL
======================

# serial_subtractor

Bit-serial two's-complement subtractor computing diff = a − b − bin one bit per clock, LSB first, with a single borrow flip-flop as the only arithmetic state. It is the inverse operation to the team's ripple-carry full-adder chain, trading latency for area. It sits behind a valid/ready input port and a valid/ready result port, so it drops into the arithmetic datapath as a multi-cycle functional unit.

## Interface
- WIDTH, default 4: operand and result width in bits (≥ 2).
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operand presented.
- in_ready  output  1  unit can accept operands (high only in IDLE).
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow in.
- out_valid  output  1  result valid (high only in DONE).
- out_ready  input  1  consumer accepts result.
- diff  output  WIDTH  (a − b − bin) mod 2^WIDTH.
- bout  output  1  borrow out (1 when a < b + bin, unsigned).
- zero  output  1  diff == 0 (bout ignored).
- ovf  output  1  signed overflow; present only with SERIAL_SUB_OVF_EN.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state IDLE.
- IDLE: in_ready = 1. On in_valid & in_ready, capture a, b into shift registers, bin into the borrow flop, clear bit counter, go to RUN.
- RUN: each cycle take bit i = LSB of each shift register:
  - d = a_i ^ b_i ^ br
  - br_next = (~a_i & b_i) | (~a_i & br) | (b_i & br)
  - shift d into the working result register from the MSB end; shift both operand registers right; increment counter.
  - After the bit with counter == WIDTH−1, go to DONE.
- Entry to DONE loads output registers: diff ← completed working result, bout ← final borrow, zero ← (result == 0), ovf ← borrow into MSB ^ borrow out of MSB.
- DONE: out_valid = 1; outputs held stable. On out_ready, go to IDLE.
- diff, bout, zero, ovf retain their last values after the handshake until the next entry to DONE; they never show partial RUN results.
- No overlap: one operation in flight at a time. in_valid outside IDLE is ignored.

## Timing
- Reset values, one edge after rst sampled high: state IDLE, in_ready 1, out_valid 0, diff 0, bout 0, zero 0, ovf 0, counter 0, borrow flop 0.
- rst has priority over every other event, including mid-RUN and during DONE. The in-flight operation is discarded and no result is produced.
- in_ready and out_valid are decoded from registered state; neither depends combinationally on in_valid or out_ready.
- Latency: accept on edge T, bits processed on edges T+1 … T+WIDTH, out_valid high from edge T+WIDTH.
- With out_ready held high, out_valid lasts exactly 1 cycle, and in_ready returns 1 on the following cycle.
- Throughput: one result per WIDTH+2 cycles at best.
- Backpressure: DONE holds indefinitely while out_ready = 0, with all outputs frozen.

## Configuration
- SERIAL_SUB_OVF_EN defined: the ovf port and the MSB borrow-in tracking flop exist, and ovf follows the rule in Operation.
- SERIAL_SUB_OVF_EN undefined: the ovf port and its logic are omitted. All other behaviour and timing are identical.

## Test plan
- Reset: assert rst 2 cycles with in_valid = 1 → in_ready = 1, out_valid = 0, diff = 0, bout = 0, zero = 0, ovf = 0, and no operation is started.
- WIDTH = 4, a = 9, b = 3, bin = 0 → out_valid exactly 4 cycles after the accept edge; diff = 6, bout = 0, zero = 0, ovf = 0.
- a = 3, b = 9, bin = 0 → diff = 10, bout = 1, zero = 0. Then a = 5, b = 4, bin = 1 → diff = 0, bout = 0, zero = 1.
- Overflow (SERIAL_SUB_OVF_EN): a = 8, b = 1 → diff = 7, ovf = 1, bout = 0. Then a = 7, b = 15 → diff = 8, ovf = 1, bout = 1.
- Backpressure: hold out_ready = 0 for 5 cycles in DONE while toggling in_valid with new operands → outputs frozen and in_ready = 0. Release → one handshake, then in_ready = 1.
- Reset mid-RUN: assert rst at bit 2 of a = 12, b = 5 → out_valid never asserted, outputs keep their reset values. A following op a = 12, b = 5 → diff = 7, bout = 0.

Source files
------------

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial two's-complement subtractor: diff = (a - b - bin) mod 2^WIDTH.
// One bit is processed per clock, LSB first. A single borrow flop carries
// the arithmetic state between bits. The operand side and the result side
// each use a valid/ready handshake, and only one operation is in flight.
//
// Ports
//   clk        in   clock, all state updates on the rising edge
//   rst        in   synchronous reset, active-high, overrides everything
//   in_valid   in   operands presented
//   in_ready   out  unit can accept operands (IDLE only)
//   a          in   [WIDTH-1:0] minuend
//   b          in   [WIDTH-1:0] subtrahend
//   bin        in   borrow in
//   out_valid  out  result valid (DONE only)
//   out_ready  in   consumer accepts result
//   diff       out  [WIDTH-1:0] (a - b - bin) mod 2^WIDTH
//   bout       out  borrow out, 1 when a < b + bin (unsigned)
//   zero       out  diff == 0 (bout ignored)
//   ovf        out  signed overflow, present only with SERIAL_SUB_OVF_EN
//
// Configuration macro: SERIAL_SUB_OVF_EN adds the ovf port and its flop.
//
// Latency: accept on edge T, bits on edges T+1..T+WIDTH, out_valid high
// from edge T+WIDTH. Result registers only change on entry to DONE, so they
// never expose partial RUN values and hold after the handshake.
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  // Bit counter must hold 0..WIDTH-1; keep at least one bit for WIDTH = 2.
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             br_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             zero_q;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q;
`endif

  // Per-bit full-subtractor slice and next working result.
  logic             a_bit;
  logic             b_bit;
  logic             d_bit;
  logic             br_d;
  logic [WIDTH-1:0] res_d;
  logic             last_bit;

  // NOTE: every signal assigned in this block gets a value on every path,
  // so no latch is inferred.
  always_comb begin
    a_bit    = a_q[0];
    b_bit    = b_q[0];
    d_bit    = a_bit ^ b_bit ^ br_q;
    br_d     = (~a_bit & b_bit) | (~a_bit & br_q) | (b_bit & br_q);
    res_d    = {d_bit, res_q[WIDTH-1:1]};
    last_bit = (cnt_q == CW'(WIDTH - 1));
  end

  // NOTE: reset is tested first inside the clocked block, so it wins over
  // every handshake and discards any operation in flight; all state uses
  // non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      zero_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            br_q    <= bin;
            cnt_q   <= '0;
            // res_q needs no clear: WIDTH shifts overwrite every bit.
            state_q <= RUN;
          end
        end

        RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          br_q  <= br_d;
          res_q <= res_d;
          cnt_q <= cnt_q + CW'(1);
          if (last_bit) begin
            diff_q  <= res_d;
            bout_q  <= br_d;
            zero_q  <= (res_d == '0);
`ifdef SERIAL_SUB_OVF_EN
            // On the MSB step br_q is the borrow into the MSB and br_d the
            // borrow out of it; they differ exactly on signed overflow.
            ovf_q   <= br_q ^ br_d;
`endif
            state_q <= DONE;
          end
        end

        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  // Handshake flags are pure decodes of the state register.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign zero      = zero_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule
